// File: rtl/alu_rr_scheduler_if.sv
// ============================================================================
// Module   : alu_rr_scheduler_if
// Brief    : Requester, response and ALU-side signal bundle for alu_rr_scheduler
// Revision : 1.0
// ============================================================================
`default_nettype none

interface alu_rr_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*8-1:0] req_a;
    logic [NUM_REQ*8-1:0] req_b;
    logic [NUM_REQ*4-1:0] req_sel;
    logic [7:0]           alu_a;
    logic [7:0]           alu_b;
    logic [3:0]           alu_sel;
    logic [15:0]          alu_result;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [15:0]          rsp_data;
    logic                 rsp_err;
    logic                 busy;
    logic [15:0]          op_count;

    // Environment side: requesters, response consumer and the ALU itself
    modport master (
        output req_valid, req_a, req_b, req_sel, rsp_ready, alu_result,
        input  req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_id,
               rsp_data, rsp_err, busy, op_count
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sel, rsp_ready, alu_result,
        output req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_id,
               rsp_data, rsp_err, busy, op_count
    );
endinterface

`default_nettype wire

// File: rtl/alu_rr_scheduler.sv
// ============================================================================
// Module   : alu_rr_scheduler
// Brief    : Round-robin sharing of one registered 8-bit ALU between requesters
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                clock,
    input  logic                reset,
    alu_rr_scheduler_if.slave   bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    localparam logic [ID_W:0]   C_NUM_REQ = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] C_PTR_RST = ID_W'(NUM_REQ - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_id;
    logic [7:0]         r_alu_a;
    logic [7:0]         r_alu_b;
    logic [3:0]         r_alu_sel;
    logic [15:0]        r_rsp_data;
    logic               r_rsp_err;
    logic [15:0]        r_op_count;

    logic               w_found;
    logic [ID_W-1:0]    w_win;
    logic [ID_W:0]      w_idx;
    logic               w_grant;
    logic               w_err;
    logic               w_rsp_fire;
    logic [NUM_REQ-1:0] w_req_ready;
    logic               w_rsp_valid;
    logic               w_busy;

    // Scan starts one past the last grant so every requester gets a turn
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (w_idx >= C_NUM_REQ) begin
                w_idx = w_idx - C_NUM_REQ;
            end
            if (!w_found && bus.req_valid[w_idx[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[ID_W-1:0];
            end
        end
    end

    assign w_grant    = (r_state == S_IDLE) && w_found;
    assign w_rsp_fire = (r_state == S_RESP) && bus.rsp_ready;
    assign w_err      = ((r_alu_sel == 4'b0011) && (r_alu_b == 8'd0)) ||
                        (r_alu_sel == 4'b0110) || (r_alu_sel == 4'b0111);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (w_found) w_next_state = S_ISSUE;
            S_ISSUE:   w_next_state = S_CAPTURE;
            S_CAPTURE: w_next_state = S_RESP;
            S_RESP:    if (bus.rsp_ready) w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Grant is masked while reset is held so all outputs read zero then
    always_comb begin
        w_req_ready = '0;
        if ((r_state == S_IDLE) && w_found && !reset) begin
            w_req_ready[w_win] = 1'b1;
        end
        w_rsp_valid = (r_state == S_RESP);
        w_busy      = (r_state != S_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ptr      <= C_PTR_RST;
            r_id       <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_sel  <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_op_count <= '0;
        end else begin
            if (w_grant) begin
                r_alu_a   <= bus.req_a[{w_win, 3'b000} +: 8];
                r_alu_b   <= bus.req_b[{w_win, 3'b000} +: 8];
                r_alu_sel <= bus.req_sel[{w_win, 2'b00} +: 4];
                r_id      <= w_win;
                r_ptr     <= w_win;
            end
            // The ALU still runs on error operands; only the reported data is masked
            if (r_state == S_CAPTURE) begin
                r_rsp_data <= w_err ? 16'h0000 : bus.alu_result;
                r_rsp_err  <= w_err;
            end
            if (w_rsp_fire) begin
                r_op_count <= r_op_count + 16'd1;
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_sel   = r_alu_sel;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_id    = r_id;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.busy      = w_busy;
    assign bus.op_count  = r_op_count;

endmodule

`default_nettype wire

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one registered 8-bit ALU (operands a/b, 4-bit select, 16-bit registered result, one-cycle latency) between NUM_REQ requesters using round-robin arbitration.
- Each requester posts an operation with a valid/ready handshake and receives a tagged response with its own valid/ready handshake.
- Sits between requester logic and the ALU instance, and drives all ALU inputs.
- The ALU shares this block's clock and reset.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester index; must equal clog2(NUM_REQ).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester operation valid
- req_ready  out  NUM_REQ  per-requester grant/accept, one-hot or zero
- req_a  in  NUM_REQ*8  packed operand A, requester i at [8i+7:8i]
- req_b  in  NUM_REQ*8  packed operand B
- req_sel  in  NUM_REQ*4  packed ALU select codes
- alu_a  out  8  operand A to ALU, registered
- alu_b  out  8  operand B to ALU, registered
- alu_sel  out  4  select to ALU, registered
- alu_result  in  16  registered ALU output
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  ID_W  index of the requester owning the response
- rsp_data  out  16  result
- rsp_err  out  1  1 = divide-by-zero or unsupported select
- busy  out  1  1 whenever state is not IDLE
- op_count  out  16  completed responses, wraps from 0xFFFF to 0

Behaviour:
- Reset values:
  - all outputs 0; state IDLE.
  - RR pointer = NUM_REQ-1, so requester 0 has top priority first.
- FSM states: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
- IDLE:
  - Search starts at pointer+1 mod NUM_REQ; the first i with req_valid[i]=1 wins.
  - req_ready[i]=1 combinationally in this cycle only; this is the handshake.
  - On the clock edge: latch req_a/req_b/req_sel of the winner into alu_a/alu_b/alu_sel; latch the winner id; set pointer=i; go to ISSUE.
  - No valid request: stay in IDLE, req_ready=0.
- ISSUE (1 cycle):
  - Hold ALU inputs stable; the ALU registers its result at the end of this cycle.
  - Go to CAPTURE.
- CAPTURE (1 cycle):
  - Latch rsp_data from alu_result, except on an error condition, where rsp_data=0x0000.
  - Latch rsp_err; go to RESP.
- RESP:
  - rsp_valid=1 with rsp_id/rsp_data/rsp_err held stable until rsp_ready=1.
  - On a cycle with rsp_valid&&rsp_ready: increment op_count and go to IDLE.
  - rsp_valid deasserts the next cycle.
- req_ready is 0 in every state other than IDLE.
- Latency: handshake cycle N -> rsp_valid first high in cycle N+3.
- Throughput: at most one operation per 4 cycles, with zero-wait rsp_ready.
- Error conditions:
  - sel=0011 with b=0 (divide-by-zero).
  - sel=0110 or 0111 (unsupported).
  - In both cases the ALU is still issued and the timing is identical.
- The pointer updates only on a grant; there is no starvation.
- A requester dropping req_valid without a handshake is legal; it is never granted.
- Mid-operation reset: return to IDLE immediately, drop the in-flight op, clear op_count, reset the pointer.
- Simultaneous events: new req_valid arriving while busy waits; the grant is evaluated on the first IDLE cycle.

Test Plan:
- Req0 a=200, b=100, sel=0000, rsp_ready=1 -> req_ready[0] cycle 0; rsp_valid cycle 3; rsp_id=0; rsp_data=0x012C; rsp_err=0; op_count=1.
- Req0 and req2 both valid and held after reset, each with a=8, b=2, sel=0011 -> grants in order 0, 2, 0, 2; each rsp_data=0x0004.
- Req1 a=5, b=0, sel=0011 -> rsp_err=1, rsp_data=0x0000. Req3 sel=0110 -> rsp_err=1, rsp_data=0x0000.
- Req0 a=9, b=9, sel=1111 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data=0x0001 held for 6 cycles; op_count increments only at the accepting cycle; no grant meanwhile.
- Reset asserted in CAPTURE -> all outputs 0 asynchronously; after release, req1 valid is granted first with pointer at NUM_REQ-1.
